// File: rtl/ib_msg_pkg.sv
// Shared IB-LUT message types and the sign/magnitude saturating conversion
// used when folding integer-domain messages back into symbol format.
package ib_msg_pkg;

   localparam int MSG_W_DEF = 4;
   localparam int IN_W_DEF  = 6;
   localparam int MAG_MAX   = 2**(MSG_W_DEF-1) - 1;

   typedef logic        [MSG_W_DEF-1:0] msg_sym_t;
   typedef logic signed [IN_W_DEF-1:0]  msg_int_t;

   typedef struct packed {
      logic        sign;
      logic [31:0] mag;
      logic        sat;
   } sm_t;

   // Split x into sign and clamped magnitude. The magnitude is formed one bit
   // wider than x so the most-negative input does not wrap. Zero has sign 0.
   function automatic sm_t sat_sm(input logic signed [31:0] x,
                                  input logic        [31:0] mag_max);
      sm_t              r;
      logic signed [32:0] xe;
      logic        [32:0] a;
      xe     = {x[31], x};
      a      = x[31] ? (33'd0 - $unsigned(xe)) : $unsigned(xe);
      r.sign = x[31];
      if (a > {1'b0, mag_max}) begin
         r.mag = mag_max;
         r.sat = 1'b1;
      end else begin
         r.mag = a[31:0];
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/iblut_int2sym_lane.sv
// One lane of the integer-to-symbol converter: clamp the two's complement
// message to the symbol magnitude range and fold the raw sign into the
// symbol sign bit.
module iblut_int2sym_lane
   import ib_msg_pkg::*;
#(
   parameter int MSG_WIDTH = MSG_W_DEF,
   parameter int IN_WIDTH  = IN_W_DEF
) (
   input  logic signed [IN_WIDTH-1:0]  int_msg,
   input  logic                        raw_sign,
   output logic        [MSG_WIDTH-1:0] sym_msg,
   output logic                        sat
);

   localparam logic [31:0] LANE_MAG_MAX = 32'((1 << (MSG_WIDTH-1)) - 1);

   sm_t  sm;
   logic unused_mag_hi;

   assign unused_mag_hi = ^sm.mag[31:MSG_WIDTH-1];

   // Symbol sign is set when the message agrees with the raw sign
   always_comb begin
      sm      = sat_sm(32'(int_msg), LANE_MAG_MAX);
      sym_msg = {~(sm.sign ^ raw_sign), sm.mag[MSG_WIDTH-2:0]};
      sat     = sm.sat;
   end

endmodule

// File: rtl/iblut_v2c_int2sym.sv
// Streaming V2C integer-to-symbol converter: two-stage valid/ready pipeline
// over LANE_NUM lanes with per-frame saturation counting and frame-length
// checking against FRAME_BEATS.
module iblut_v2c_int2sym
   import ib_msg_pkg::*;
#(
   parameter  int MSG_WIDTH   = MSG_W_DEF,
   parameter  int IN_WIDTH    = IN_W_DEF,
   parameter  int LANE_NUM    = 8,
   parameter  int FRAME_BEATS = 16,
   localparam int CNT_W       = $clog2(LANE_NUM*FRAME_BEATS+1)
) (
   input  logic                          sys_clk,
   input  logic                          rst,
   input  logic                          int_valid_i,
   output logic                          int_ready_o,
   input  logic [LANE_NUM*IN_WIDTH-1:0]  int_msg_i,
   input  logic [LANE_NUM-1:0]           raw_sign_i,
   input  logic                          int_last_i,
   output logic                          sym_valid_o,
   input  logic                          sym_ready_i,
   output logic [LANE_NUM*MSG_WIDTH-1:0] sym_msg_o,
   output logic                          sym_last_o,
   output logic [CNT_W-1:0]              sat_cnt_o,
   output logic                          sat_cnt_vld_o,
   output logic                          frame_err_o
);

   localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

   logic [LANE_NUM*MSG_WIDTH-1:0] sym_c, sym_p1, sym_p2;
   logic [LANE_NUM-1:0]           sat_c, sat_p1;
   logic                          last_p1, last_p2;
   logic                          vld_p1, vld_p2;
   logic                          accept, s2_adv, beat_end;
   logic [BEAT_W-1:0]             beat_cnt;
   logic [CNT_W-1:0]              acc, pop_p1, sat_cnt;
   logic                          sat_cnt_vld, frame_err;

   function automatic logic [CNT_W-1:0] popcount(input logic [LANE_NUM-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < LANE_NUM; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
      iblut_int2sym_lane #(
         .MSG_WIDTH (MSG_WIDTH),
         .IN_WIDTH  (IN_WIDTH)
      ) u_lane (
         .int_msg  (int_msg_i[k*IN_WIDTH +: IN_WIDTH]),
         .raw_sign (raw_sign_i[k]),
         .sym_msg  (sym_c[k*MSG_WIDTH +: MSG_WIDTH]),
         .sat      (sat_c[k])
      );
   end

   assign s2_adv      = vld_p1 & (~vld_p2 | sym_ready_i);
   assign int_ready_o = ~vld_p1 | s2_adv;
   assign accept      = int_valid_i & int_ready_o;
   assign beat_end    = (beat_cnt == BEAT_W'(FRAME_BEATS-1));
   assign pop_p1      = popcount(sat_p1);

   // Stage 1 boundary: lane results captured only when a beat is accepted
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         sym_p1  <= sym_c;
         sat_p1  <= sat_c;
         last_p1 <= int_last_i;
      end
   end

   // Stage 2 boundary: output register, stage valids, beat counter and frame saturation count
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         sym_p2      <= '0;
         last_p2     <= 1'b0;
         beat_cnt    <= '0;
         acc         <= '0;
         sat_cnt     <= '0;
         sat_cnt_vld <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         sat_cnt_vld <= 1'b0;

         if (accept)      vld_p1 <= 1'b1;
         else if (s2_adv) vld_p1 <= 1'b0;

         if (s2_adv) begin
            vld_p2  <= 1'b1;
            sym_p2  <= sym_p1;
            last_p2 <= last_p1;
            if (last_p1) begin
               sat_cnt     <= acc + pop_p1;
               sat_cnt_vld <= 1'b1;
               acc         <= '0;
            end else begin
               acc <= acc + pop_p1;
            end
         end else if (sym_ready_i) begin
            vld_p2 <= 1'b0;
         end

         // Counter resynchronises on any last flag, early or on time
         if (accept) begin
            if (int_last_i != beat_end) frame_err <= 1'b1;
            beat_cnt <= (int_last_i | beat_end) ? '0 : beat_cnt + BEAT_W'(1);
         end
      end
   end

   assign sym_valid_o   = vld_p2;
   assign sym_msg_o     = sym_p2;
   assign sym_last_o    = last_p2;
   assign sat_cnt_o     = sat_cnt;
   assign sat_cnt_vld_o = sat_cnt_vld;
   assign frame_err_o   = frame_err;

endmodule

// File: tb/tb_iblut_v2c_int2sym.sv
// Directed bench for iblut_v2c_int2sym with default parameters.
module tb_iblut_v2c_int2sym;

   localparam int LN = 8;
   localparam int IW = 6;
   localparam int MW = 4;
   localparam int CW = 8;

   logic                 sys_clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 int_valid_i = 1'b0;
   logic                 int_ready_o;
   logic [LN*IW-1:0]     int_msg_i = '0;
   logic [LN-1:0]        raw_sign_i = '0;
   logic                 int_last_i = 1'b0;
   logic                 sym_valid_o;
   logic                 sym_ready_i = 1'b1;
   logic [LN*MW-1:0]     sym_msg_o;
   logic                 sym_last_o;
   logic [CW-1:0]        sat_cnt_o;
   logic                 sat_cnt_vld_o;
   logic                 frame_err_o;

   int n_chk = 0;
   int n_fail = 0;
   int pulse_cnt = 0;
   logic [LN*MW:0] out_q[$];

   logic signed [IW-1:0] bx[LN];
   logic [LN-1:0]        br;

   iblut_v2c_int2sym dut (
      .sys_clk       (sys_clk),
      .rst           (rst),
      .int_valid_i   (int_valid_i),
      .int_ready_o   (int_ready_o),
      .int_msg_i     (int_msg_i),
      .raw_sign_i    (raw_sign_i),
      .int_last_i    (int_last_i),
      .sym_valid_o   (sym_valid_o),
      .sym_ready_i   (sym_ready_i),
      .sym_msg_o     (sym_msg_o),
      .sym_last_o    (sym_last_o),
      .sat_cnt_o     (sat_cnt_o),
      .sat_cnt_vld_o (sat_cnt_vld_o),
      .frame_err_o   (frame_err_o)
   );

   always #5 sys_clk = ~sys_clk;

   // Output transfers and count-valid pulses as seen at each rising edge
   always @(posedge sys_clk) begin
      if (!rst && sym_valid_o && sym_ready_i) out_q.push_back({sym_last_o, sym_msg_o});
      if (!rst && sat_cnt_vld_o) pulse_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_lanes();
      for (int k = 0; k < LN; k++) bx[k] = '0;
      br = '0;
   endtask

   // Present one beat and hold it until it is accepted
   task automatic send(input logic last);
      logic taken;
      for (int k = 0; k < LN; k++) int_msg_i[k*IW +: IW] = bx[k];
      raw_sign_i  = br;
      int_last_i  = last;
      int_valid_i = 1'b1;
      taken = 1'b0;
      for (int c = 0; c < 50 && !taken; c++) begin
         #1;
         taken = int_ready_o;
         @(posedge sys_clk);
         #1;
      end
      if (!taken) check("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic idle(input int n);
      int_valid_i = 1'b0;
      int_last_i  = 1'b0;
      repeat (n) tick();
   endtask

   // Stall-frame beat i: lane0 = i-8 with raw sign i[0], all other lanes zero
   function automatic logic [LN*MW-1:0] stall_exp(input int i);
      int         x;
      logic       sgn, top;
      logic [2:0] mag;
      x   = i - 8;
      sgn = (x < 0);
      mag = (x < -7) ? 3'd7 : (x < 0 ? 3'(-x) : 3'(x));
      top = ~(sgn ^ i[0]);
      return 32'h8888_8880 | {28'h0, top, mag};
   endfunction

   initial begin
      int p0;
      logic [LN*MW-1:0] held;

      // Reset
      clear_lanes();
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_sym_valid", 64'(sym_valid_o), 64'(0));
      check("rst_sym_msg", 64'(sym_msg_o), 64'(0));
      check("rst_sym_last", 64'(sym_last_o), 64'(0));
      check("rst_sat_cnt", 64'(sat_cnt_o), 64'(0));
      check("rst_sat_vld", 64'(sat_cnt_vld_o), 64'(0));
      check("rst_frame_err", 64'(frame_err_o), 64'(0));
      check("rst_int_ready", 64'(int_ready_o), 64'(1));
      tick();

      // Frame 1: basic fold, then two saturating lanes
      p0 = pulse_cnt;
      clear_lanes();
      bx[0] = 6'sd5;  br[0] = 1'b1;
      bx[1] = -6'sd3; br[1] = 1'b0;
      send(1'b0);
      clear_lanes();
      bx[0] = 6'sd20;  br[0] = 1'b0;
      bx[1] = -6'sd32; br[1] = 1'b1;
      send(1'b0);
      check("basic_valid", 64'(sym_valid_o), 64'(1));
      check("basic_sym", 64'(sym_msg_o), 64'(32'h8888_8835));
      check("basic_last", 64'(sym_last_o), 64'(0));
      clear_lanes();
      send(1'b0);
      check("sat_sym", 64'(sym_msg_o), 64'(32'h8888_88FF));
      for (int b = 3; b < 16; b++) send(b == 15);
      idle(1);
      check("f1_sat_cnt", 64'(sat_cnt_o), 64'(2));
      check("f1_sat_vld", 64'(sat_cnt_vld_o), 64'(1));
      check("f1_last", 64'(sym_last_o), 64'(1));
      idle(1);
      check("f1_sat_vld_off", 64'(sat_cnt_vld_o), 64'(0));
      idle(1);
      check("f1_pulses", 64'(pulse_cnt - p0), 64'(1));

      // Frame 2: every lane saturates on every beat
      p0 = pulse_cnt;
      for (int k = 0; k < LN; k++) bx[k] = 6'sd31;
      br = '0;
      for (int b = 0; b < 16; b++) send(b == 15);
      idle(1);
      check("f2_sat_cnt", 64'(sat_cnt_o), 64'(128));
      check("f2_sat_vld", 64'(sat_cnt_vld_o), 64'(1));
      check("f2_sym", 64'(sym_msg_o), 64'(32'hFFFF_FFFF));
      idle(3);
      check("f2_pulses", 64'(pulse_cnt - p0), 64'(1));
      check("f2_frame_err", 64'(frame_err_o), 64'(0));

      // Frame 3: output stall in the middle of a continuous stream
      out_q.delete();
      p0 = pulse_cnt;
      fork
         begin
            for (int b = 0; b < 16; b++) begin
               clear_lanes();
               bx[0] = IW'(b - 8);
               br[0] = b[0];
               send(b == 15);
            end
            idle(1);
         end
         begin
            repeat (5) tick();
            sym_ready_i = 1'b0;
            #1;
            held = sym_msg_o;
            check("stall_vld0", 64'(sym_valid_o), 64'(1));
            check("stall_rdy0", 64'(int_ready_o), 64'(0));
            for (int c = 0; c < 4; c++) begin
               @(posedge sys_clk);
               #2;
               check("stall_rdy", 64'(int_ready_o), 64'(0));
               check("stall_hold", 64'(sym_msg_o), 64'(held));
               check("stall_vld", 64'(sym_valid_o), 64'(1));
            end
            @(posedge sys_clk);
            #1;
            sym_ready_i = 1'b1;
         end
      join
      idle(4);
      check("stall_count", 64'(out_q.size()), 64'(16));
      for (int i = 0; i < 16 && i < out_q.size(); i++) begin
         check("stall_data", 64'(out_q[i][LN*MW-1:0]), 64'(stall_exp(i)));
         check("stall_lastflag", 64'(out_q[i][LN*MW]), 64'(i == 15));
      end
      check("f3_sat_cnt", 64'(sat_cnt_o), 64'(1));
      check("f3_pulses", 64'(pulse_cnt - p0), 64'(1));

      // Frame 4: early last on beat 10
      for (int b = 0; b < 11; b++) begin
         clear_lanes();
         if (b == 3)  bx[5] = -6'sd20;
         if (b == 10) bx[7] = 6'sd8;
         send(b == 10);
         if (b == 9) check("early_err_before", 64'(frame_err_o), 64'(0));
      end
      check("early_err_set", 64'(frame_err_o), 64'(1));
      idle(1);
      check("early_sat_cnt", 64'(sat_cnt_o), 64'(2));
      check("early_sat_vld", 64'(sat_cnt_vld_o), 64'(1));
      clear_lanes();
      for (int b = 0; b < 16; b++) send(b == 15);
      idle(1);
      check("early_err_sticky", 64'(frame_err_o), 64'(1));
      check("after_early_sat_cnt", 64'(sat_cnt_o), 64'(0));
      idle(2);

      // Reset with beats in flight mid-frame
      for (int k = 0; k < LN; k++) bx[k] = 6'sd31;
      br = '0;
      for (int b = 0; b < 4; b++) send(1'b0);
      int_valid_i = 1'b0;
      p0 = pulse_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 64'(sym_valid_o), 64'(0));
      check("mid_rst_ready", 64'(int_ready_o), 64'(1));
      check("mid_rst_err", 64'(frame_err_o), 64'(0));
      check("mid_rst_sat_cnt", 64'(sat_cnt_o), 64'(0));
      idle(3);
      check("mid_rst_no_pulse", 64'(pulse_cnt - p0), 64'(0));
      for (int b = 0; b < 16; b++) begin
         clear_lanes();
         if (b == 0)  bx[0] = 6'sd31;
         if (b == 15) bx[7] = -6'sd31;
         send(b == 15);
      end
      idle(1);
      check("post_rst_sat_cnt", 64'(sat_cnt_o), 64'(2));
      check("post_rst_sat_vld", 64'(sat_cnt_vld_o), 64'(1));
      check("post_rst_err", 64'(frame_err_o), 64'(0));
      idle(2);
      check("post_rst_pulses", 64'(pulse_cnt - p0), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
